dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbiter that shares the single-port synchronous data memory between the processor core and the debug/loader port. It grants at most one access per cycle, alternates round-robin on contention, and supports bounded locked bursts for the loader. It routes read data back to the owner one cycle later and drives a stall to the core while its request waits.

## Interface
Parameters:
- ADDR_WIDTH, 8, memory address width; set to MEM_WIDTH at instantiation.
- DATA_WIDTH, 8, data word width; set to VALUE_WIDTH at instantiation.
- LOCK_MAX, 4, maximum consecutive locked debug grants before a forced yield; legal range 1–15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- core_req  in  1  core access request; held with stable command until granted.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_WIDTH  core address.
- core_wdata  in  DATA_WIDTH  core write data.
- core_gnt  out  1  core command accepted this cycle.
- core_stall  out  1  core_req && !core_gnt.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_WIDTH  core read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  debug command, same rules as core.
- dbg_lock  in  1  request locked burst; sampled only with dbg_req.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_WIDTH  debug grant, read valid, read data.
- mem_en, mem_we  out  1  memory enable / write enable.
- mem_addr, mem_wdata  out  ADDR_WIDTH/DATA_WIDTH  memory command.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after a read with mem_en.

## Operation
- State: rr_last (0 = core, 1 = dbg), lock_cnt (4 bits), yield flag, rd_owner/rd_pend registers.
- Arbitration per cycle, combinational from req inputs and registered state:
  - One requester only: it is granted.
  - Both, yield = 1: core is granted.
  - Both, lock active (rr_last = dbg, dbg_lock = 1, lock_cnt < LOCK_MAX): dbg is granted.
  - Both, otherwise: the requester not equal to rr_last is granted.
- The granted command drives mem_*; mem_en = core_gnt | dbg_gnt. With no grant, mem_* are 0.
- lock_cnt:
  - Increments on a dbg grant with dbg_lock.
  - Clears on a core grant, a dbg grant without lock, or any cycle without dbg_req.
  - On reaching LOCK_MAX with core_req pending, yield is set. yield clears after the next core grant.
- Reads: a granted read sets rd_pend and rd_owner for the next cycle. Writes produce no rvalid.
- xx_rdata = mem_rdata when owned, else 0.

## Timing
- Grant is combinational in the request cycle. The memory command is issued in the same cycle.
- Read latency: rvalid and rdata are asserted exactly 1 cycle after the gnt cycle for the owner only.
- Back-to-back grants are allowed every cycle. Throughput is 1 access per cycle.
- Reset values: rr_last = 1 (core wins the first tie), lock_cnt = 0, yield = 0, rd_pend = 0.
  - All gnt, rvalid, rdata and mem_* outputs are 0 while rst = 0.
  - core_stall = 0 while rst = 0.
- Reset mid-operation: a pending read is discarded and no rvalid follows. Arbitration restarts from reset state on the first edge after rst rises.
- dbg_lock without dbg_req has no effect. Dropping dbg_lock mid-burst ends the lock immediately; normal round-robin applies that cycle.
- A request withdrawn before grant is legal and leaves no side effects.

## Test plan
- Core only:
  - Write addr 0x10 data 0xA5, then read 0x10.
  - Required: core_gnt in each request cycle, core_stall = 0, core_rvalid 1 cycle after the read with core_rdata = 0xA5, dbg_rvalid = 0.
- Contention:
  - Both request reads continuously for 6 cycles after reset.
  - Required: grants alternate core, dbg, core, dbg, core, dbg. core_stall is high on dbg cycles. Each rvalid goes to the correct owner.
- Locked burst:
  - LOCK_MAX = 4. dbg_req and dbg_lock held 8 cycles with core_req high from cycle 1.
  - Required: dbg granted cycles 1–4, core granted cycle 5, dbg granted cycles 6–8 (counter restarted).
- Lock without contention:
  - dbg locks 10 writes, core idle.
  - Required: 10 consecutive dbg_gnt, no yield gaps, memory contents correct.
- Reset mid-read:
  - Core read granted, rst asserted low asynchronously before the next edge.
  - Required: all outputs 0 immediately, no core_rvalid. After release, a tied request grants core first.
- Withdrawn request:
  - dbg_req pulsed 1 cycle while the core holds the grant turn.
  - Required: no dbg_gnt, no memory access from dbg, rr_last unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the core and the debug/loader port.
// Round-robin on contention, bounded locked debug bursts, read data routed to its owner one cycle later.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_stall,
    output logic                  core_rvalid,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic                  dbg_lock,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned       CNT_W     = 4;
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

    logic             r_rr_last;   // 0 = core, 1 = dbg was granted last
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_yield;
    logic             r_rd_pend;
    logic             r_rd_owner;  // 0 = core, 1 = dbg

    logic             w_core_win;
    logic             w_dbg_win;
    logic             w_lock_act;
    logic             w_lock_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_yield_nxt;

    assign w_lock_act = r_rr_last & dbg_lock & (r_lock_cnt < CNT_LIMIT);

    // Arbitration: single requester wins, then yield, then lock, then round-robin.
    always_comb begin
        w_core_win = 1'b0;
        w_dbg_win  = 1'b0;
        if (rst) begin
            if (!(core_req && dbg_req)) begin
                w_core_win = core_req;
                w_dbg_win  = dbg_req;
            end else if (r_yield) begin
                w_core_win = 1'b1;
            end else if (w_lock_act) begin
                w_dbg_win  = 1'b1;
            end else if (r_rr_last) begin
                w_core_win = 1'b1;
            end else begin
                w_dbg_win  = 1'b1;
            end
        end
    end

    assign core_gnt   = w_core_win;
    assign dbg_gnt    = w_dbg_win;
    assign core_stall = rst & core_req & ~w_core_win;
    assign mem_en     = w_core_win | w_dbg_win;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_core_win) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_dbg_win) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Lock counter saturates so a long uncontended burst never wraps back into lock range.
    assign w_lock_inc = w_dbg_win & dbg_lock;

    always_comb begin
        w_cnt_nxt   = r_lock_cnt;
        w_yield_nxt = r_yield;
        if (w_lock_inc) begin
            w_cnt_nxt = (r_lock_cnt == CNT_SAT) ? CNT_SAT : r_lock_cnt + CNT_W'(1);
        end else if (w_core_win || w_dbg_win || !dbg_req) begin
            w_cnt_nxt = '0;
        end
        if (w_core_win) begin
            w_yield_nxt = 1'b0;
        end else if (w_lock_inc && (w_cnt_nxt >= CNT_LIMIT) && core_req) begin
            w_yield_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_last  <= 1'b1;
            r_lock_cnt <= '0;
            r_yield    <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_core_win) begin
                r_rr_last <= 1'b0;
            end else if (w_dbg_win) begin
                r_rr_last <= 1'b1;
            end
            r_lock_cnt <= w_cnt_nxt;
            r_yield    <= w_yield_nxt;
            r_rd_pend  <= mem_en & ~mem_we;
            r_rd_owner <= w_dbg_win;
        end
    end

    assign core_rvalid = r_rd_pend & ~r_rd_owner;
    assign dbg_rvalid  = r_rd_pend & r_rd_owner;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign dbg_rdata   = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset-mid-read sequence, and random traffic vs a rule-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 8;
    localparam int unsigned LOCK_MAX = 4;

    logic          clk;
    logic          rst;
    logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] core_addr, dbg_addr, mem_addr;
    logic [DW-1:0] core_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic          core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [DW-1:0] core_rdata, dbg_rdata;

    logic [DW-1:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        bit          rb;
        bit          cr, cw;
        logic [7:0]  ca, cd;
        bit          dr, dw, dl;
        logic [7:0]  da, dd;
        bit          ecg, edg, ecv, edv;
        logic [7:0]  ecr, edr;
    } vec_t;

    vec_t vt[$];

    // Reference model state (rule level).
    int         m_last;      // 0 core, 1 dbg
    int         m_cnt;
    bit         m_yield;
    bit         m_pend;
    int         m_owner;
    logic [7:0] m_data;
    logic [7:0] shadow [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    endtask

    // Pulse reset with both sides requesting; all outputs must stay low meanwhile.
    task automatic do_reset();
        rst = 1'b0;
        core_req = 1; dbg_req = 1;
        #1;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_stall", core_stall, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_rvalid", {core_rvalid, dbg_rvalid}, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic addv(input bit rb, input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                        input bit dr, input bit dw, input bit dl, input logic [7:0] da, input logic [7:0] dd,
                        input bit ecg, input bit edg, input bit ecv, input bit edv,
                        input logic [7:0] ecr, input logic [7:0] edr);
        vec_t v;
        v.rb = rb; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
        v.ecg = ecg; v.edg = edg; v.ecv = ecv; v.edv = edv; v.ecr = ecr; v.edr = edr;
        vt.push_back(v);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        string s;
        if (v.rb) do_reset();
        core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
        dbg_req = v.dr; dbg_we = v.dw; dbg_lock = v.dl; dbg_addr = v.da; dbg_wdata = v.dd;
        @(negedge clk);
        s = $sformatf("v%0d", idx);
        check({s, "_core_gnt"}, core_gnt, v.ecg);
        check({s, "_dbg_gnt"}, dbg_gnt, v.edg);
        check({s, "_stall"}, core_stall, v.cr & ~v.ecg);
        check({s, "_mem_en"}, mem_en, v.ecg | v.edg);
        check({s, "_mem_we"}, mem_we, v.ecg ? v.cw : (v.edg ? v.dw : 1'b0));
        check({s, "_mem_addr"}, mem_addr, v.ecg ? v.ca : (v.edg ? v.da : 8'h00));
        check({s, "_core_rvalid"}, core_rvalid, v.ecv);
        check({s, "_dbg_rvalid"}, dbg_rvalid, v.edv);
        check({s, "_core_rdata"}, core_rdata, v.ecr);
        check({s, "_dbg_rdata"}, dbg_rdata, v.edr);
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input bit cr, input bit dr, input bit dl);
        if (!cr && !dr) return 0;
        if (cr && !dr)  return 1;
        if (dr && !cr)  return 2;
        if (m_yield)    return 1;
        if (m_last == 1 && dl && m_cnt < int'(LOCK_MAX)) return 2;
        return (m_last == 1) ? 1 : 2;
    endfunction

    task automatic rand_cycle(input int n);
        int         w;
        logic [7:0] ea;
        @(negedge clk);
        w  = pick(core_req, dbg_req, dbg_lock);
        ea = (w == 1) ? core_addr : ((w == 2) ? dbg_addr : 8'h00);
        check($sformatf("r%0d_core_gnt", n), core_gnt, w == 1);
        check($sformatf("r%0d_dbg_gnt", n), dbg_gnt, w == 2);
        check($sformatf("r%0d_stall", n), core_stall, core_req && w != 1);
        check($sformatf("r%0d_mem_en", n), mem_en, w != 0);
        check($sformatf("r%0d_mem_we", n), mem_we, (w == 1) ? core_we : ((w == 2) ? dbg_we : 1'b0));
        check($sformatf("r%0d_mem_addr", n), mem_addr, ea);
        check($sformatf("r%0d_mem_wdata", n), mem_wdata,
              (w == 1) ? core_wdata : ((w == 2) ? dbg_wdata : 8'h00));
        check($sformatf("r%0d_core_rvalid", n), core_rvalid, m_pend && m_owner == 0);
        check($sformatf("r%0d_dbg_rvalid", n), dbg_rvalid, m_pend && m_owner == 1);
        check($sformatf("r%0d_core_rdata", n), core_rdata, (m_pend && m_owner == 0) ? m_data : 8'h00);
        check($sformatf("r%0d_dbg_rdata", n), dbg_rdata, (m_pend && m_owner == 1) ? m_data : 8'h00);
        // Advance the model across the coming edge.
        if (w == 2 && dbg_lock)          m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
        else if (w != 0 || !dbg_req)     m_cnt = 0;
        if (w == 1)                      m_yield = 0;
        else if (w == 2 && dbg_lock && m_cnt >= int'(LOCK_MAX) && core_req) m_yield = 1;
        if (w != 0) m_last = w - 1;
        m_pend = 0;
        if (w != 0) begin
            if ((w == 1) ? core_we : dbg_we) begin
                shadow[ea] = (w == 1) ? core_wdata : dbg_wdata;
            end else begin
                m_pend  = 1;
                m_owner = w - 1;
                m_data  = shadow[ea];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit cgot, dgot;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        mem_rdata = '0;
        rst = 1'b0;
        idle_inputs();

        // Core only
        addv(1, 1,1,8'h10,8'hA5, 0,0,0,8'h00,8'h00, 1,0,0,0, 8'h00,8'h00);
        addv(0, 0,0,8'h00,8'h00, 1,1,0,8'h11,8'h3C, 0,1,0,0, 8'h00,8'h00);
        addv(0, 1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0, 8'h00,8'h00);
        addv(0, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,1,0, 8'hA5,8'h00);
        // Contention: alternating grants, data back to the right owner
        for (int i = 0; i < 6; i++)
            addv(i == 0, 1,0,8'h10,8'h00, 1,0,0,8'h11,8'h00, (i % 2) == 0, (i % 2) == 1,
                 i > 0 && (i % 2) == 1, i > 0 && (i % 2) == 0,
                 (i > 0 && (i % 2) == 1) ? 8'hA5 : 8'h00, (i > 0 && (i % 2) == 0) ? 8'h3C : 8'h00);
        addv(0, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1, 8'h00,8'h3C);
        // Locked burst with core contending from the first cycle
        for (int i = 0; i < 8; i++)
            addv(i == 0, 1,0,8'h10,8'h00, 1,1,1,8'(8'h40 + i),8'(8'h90 + i), i == 4, i != 4,
                 i == 5, 0, (i == 5) ? 8'hA5 : 8'h00, 8'h00);
        // Lock without contention, then read back
        for (int i = 0; i < 10; i++)
            addv(i == 0, 0,0,8'h00,8'h00, 1,1,1,8'(8'h50 + i),8'(8'h80 + i), 0,1,0,0, 8'h00,8'h00);
        addv(0, 1,0,8'h52,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,0, 8'h00,8'h00);
        addv(0, 0,0,8'h00,8'h00, 1,0,0,8'h59,8'h00, 0,1,1,0, 8'h82,8'h00);
        addv(0, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1, 8'h00,8'h89);
        // Withdrawn dbg write while core holds the turn; address must stay unwritten
        addv(1, 1,0,8'h10,8'h00, 1,1,0,8'h60,8'hFF, 1,0,0,0, 8'h00,8'h00);
        addv(0, 0,0,8'h00,8'h00, 1,0,0,8'h60,8'h00, 0,1,1,0, 8'hA5,8'h00);
        addv(0, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,1, 8'h00,8'h00);

        @(posedge clk);
        #1;
        foreach (vt[i]) apply_vec(i, vt[i]);

        // Reset mid-read: read granted, reset before the edge, then a tie goes to core
        idle_inputs();
        core_req = 1; core_we = 1; core_addr = 8'h70; core_wdata = 8'h11;
        @(negedge clk);
        check("rmr_pre_gnt", core_gnt, 1);
        @(posedge clk);
        #1;
        core_we = 0; core_addr = 8'h10;
        @(negedge clk);
        check("rmr_read_gnt", core_gnt, 1);
        #2;
        rst = 1'b0;
        dbg_req = 1; dbg_addr = 8'h11;
        #1;
        check("rmr_async_gnt", {core_gnt, dbg_gnt}, 0);
        check("rmr_async_stall", core_stall, 0);
        check("rmr_async_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        @(posedge clk);
        #1;
        check("rmr_no_rvalid", {core_rvalid, dbg_rvalid, core_rdata, dbg_rdata}, 0);
        #2 rst = 1'b1;
        @(negedge clk);
        check("rmr_tie_core_gnt", core_gnt, 1);
        check("rmr_tie_dbg_gnt", dbg_gnt, 0);
        check("rmr_tie_rvalid", core_rvalid, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("rmr_after_rvalid", core_rvalid, 1);
        check("rmr_after_rdata", core_rdata, 8'hA5);
        @(posedge clk);
        #1;

        // Random traffic against the rule-level model in an untouched address window
        do_reset();
        m_last = 1; m_cnt = 0; m_yield = 0; m_pend = 0; m_owner = 0; m_data = '0;
        cgot = 1; dgot = 1;
        for (int n = 0; n < 600; n++) begin
            if (cgot || $urandom_range(3) == 0) begin
                core_req = $urandom_range(2) != 0; core_we = $urandom_range(1) != 0;
                core_addr = 8'(8'hC0 + $urandom_range(7)); core_wdata = 8'($urandom);
            end
            if (dgot || $urandom_range(3) == 0) begin
                dbg_req = $urandom_range(2) != 0; dbg_we = $urandom_range(1) != 0;
                dbg_addr = 8'(8'hC0 + $urandom_range(7)); dbg_wdata = 8'($urandom);
            end
            dbg_lock = $urandom_range(3) != 0;
            cgot = (pick(core_req, dbg_req, dbg_lock) == 1) || !core_req;
            dgot = (pick(core_req, dbg_req, dbg_lock) == 2) || !dbg_req;
            rand_cycle(n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
